aead_tag_verifier: RTL and testbench
====================================

AEAD_TAG_VERIFIER -- requirements
Module: aead_tag_verifier

Interface
REQ-001 SHALL have parameter Y, default 40, meaning plaintext length in bits (Y >= 1).
REQ-002 SHALL have parameter T, default 128, meaning tag length in bits.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port exp_bit  input  1  expected tag bit from the receiver, bit index 0 first.
REQ-006 SHALL have port exp_valid  input  1  qualifies exp_bit.
REQ-007 SHALL have port dec_bit_pt  input  1  computed plaintext bit from the decryption stage, index 0 first.
REQ-008 SHALL have port dec_bit_tag  input  1  computed tag bit from the decryption stage, index 0 first.
REQ-009 SHALL have port dec_valid  input  1  qualifies both dec_bit_* streams; cycle n carries pt bit n (n<Y) and tag bit n (n<T).
REQ-010 SHALL have port pt_out  output  1  released plaintext bit.
REQ-011 SHALL have port pt_out_valid  output  1  qualifies pt_out.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of a message.
REQ-013 SHALL have port auth_ok  output  1  verdict, valid from done until next message start.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> COLLECT -> RELEASE|FAIL -> IDLE.
REQ-016 SHALL leave IDLE for LOAD on the first exp_valid cycle; that bit is stored as index 0.
REQ-017 SHALL in LOAD shift exp_bit into a T-bit register on each exp_valid, counter 0..T-1; after bit T-1 go COLLECT.
REQ-018 SHALL ignore dec_valid while in IDLE or LOAD.
REQ-019 SHALL in COLLECT, per dec_valid cycle n: store pt bit n into a Y-bit buffer if n<Y; compare tag bit n against stored expected bit n if n<T, OR-accumulating a mismatch flag.
REQ-020 SHALL end COLLECT after max(Y,T) dec_valid cycles; next state RELEASE if mismatch flag clear, else FAIL.
REQ-021 SHALL in RELEASE drive pt_out_valid high for exactly Y consecutive cycles, pt_out = buffer bit 0 first, then pulse done with auth_ok=1 on the cycle after the last bit.
REQ-022 SHALL in FAIL never assert pt_out_valid, hold pt_out=0, pulse done with auth_ok=0 one cycle after entry, and zero the plaintext buffer on that same cycle.
REQ-023 SHALL return to IDLE on the cycle after done; auth_ok holds its value until the next LOAD entry, where it clears to 0.
REQ-024 SHALL ignore exp_valid outside IDLE/LOAD, and ignore dec_valid in RELEASE/FAIL.
REQ-025 SHALL size counters as ceil(log2(max(Y,T)+1)) bits; no wrap occurs within a message.
REQ-026 SHALL keep pt_out=0 whenever pt_out_valid=0.

Reset
REQ-027 SHALL on rst force state IDLE, clear counters, mismatch flag, tag register, plaintext buffer; outputs pt_out=0, pt_out_valid=0, done=0, auth_ok=0, busy=0.
REQ-028 SHALL abort any message on rst mid-operation with no done pulse; rst dominates all other inputs in the same cycle.

Configuration
REQ-029 SHALL honour macro AEAD_TAGV_EARLY_ABORT_EN: when defined, the first tag mismatch in COLLECT moves to FAIL on the next cycle, skipping remaining dec_valid bits.
REQ-030 SHALL without AEAD_TAGV_EARLY_ABORT_EN always consume all max(Y,T) bits before verdict (constant-time default).

Structure
REQ-031 SHALL take state encoding (IDLE, LOAD, COLLECT, RELEASE, FAIL) and default T=128 from the shared package ascon_pkg.
REQ-032 SHALL be a single module with one natural sub-module, aead_bit_shifter (parameterised width serial-in/serial-out register) used for tag and plaintext storage.

Verification
REQ-033 SHALL check Y=40: matching 128-bit tag, pt stream 0xA5A5A5A5A5 bit0-first -> 40 pt_out_valid cycles reproducing it, then done with auth_ok=1.
REQ-034 SHALL check tag bit 127 flipped -> no pt_out_valid, done with auth_ok=0, buffer reads all zero afterwards.
REQ-035 SHALL check with early abort defined, tag bit 3 flipped -> FAIL entered on the cycle after dec bit 3, done 1 cycle later; without macro -> done after all 128 bits.
REQ-036 SHALL check Y=200 (Y>T): all 200 pt bits buffered and released, verdict from bits 0..127 only.
REQ-037 SHALL check rst asserted in the middle of COLLECT -> all outputs 0 next cycle, no done, and a following full message passes with auth_ok=1.
REQ-038 SHALL check gapped dec_valid (one idle cycle between every bit) -> identical result to back-to-back stimulus.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared definitions for the AEAD tag verifier: FSM state encoding and default tag length.
package ascon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COLLECT,
    ST_RELEASE,
    ST_FAIL
  } state_t;

  localparam int unsigned T_DEFAULT = 128;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aead_bit_shifter.sv
// Serial-in/serial-out register: new bits enter at the MSB, the oldest bit is presented at the LSB.
module aead_bit_shifter #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_shift,
  input  logic i_ser,
  output logic o_ser
);

  logic [W-1:0] r_data;

  generate
    if (W == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst || i_clr) r_data <= '0;
        else if (i_shift) r_data <= i_ser;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst || i_clr) r_data <= '0;
        else if (i_shift) r_data <= {i_ser, r_data[W-1:1]};
      end
    end
  endgenerate

  assign o_ser = r_data[0];

endmodule

// File: rtl/aead_tag_verifier.sv
// Buffers decrypted plaintext and releases it only after the streamed tag matches the expected tag.
// Optional AEAD_TAGV_EARLY_ABORT_EN: leave COLLECT at the first tag mismatch instead of constant time.
module aead_tag_verifier
  import ascon_pkg::*;
#(
  parameter int unsigned Y = 40,
  parameter int unsigned T = T_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic exp_bit,
  input  logic exp_valid,
  input  logic dec_bit_pt,
  input  logic dec_bit_tag,
  input  logic dec_valid,
  output logic pt_out,
  output logic pt_out_valid,
  output logic done,
  output logic auth_ok,
  output logic busy
);

  localparam int unsigned N  = max_u(Y, T);
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] L_Y   = CW'(Y);
  localparam logic [CW-1:0] L_T   = CW'(T);
  localparam logic [CW-1:0] L_TM1 = CW'(T - 1);
  localparam logic [CW-1:0] L_NM1 = CW'(N - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mis;
  logic          r_pt_out;
  logic          r_pt_valid;
  logic          r_done;
  logic          r_auth_ok;

  logic w_tag_lsb, w_pt_lsb;
  logic w_tag_shift, w_tag_in;
  logic w_pt_shift, w_pt_in, w_pt_clr;
  logic w_take, w_bit_mis, w_abort;

  always_comb begin
    w_take      = (r_state == ST_COLLECT) && dec_valid;
    w_bit_mis   = w_take && (r_cnt < L_T) && (dec_bit_tag != w_tag_lsb);
`ifdef AEAD_TAGV_EARLY_ABORT_EN
    w_abort     = w_bit_mis;
`else
    w_abort     = 1'b0;
`endif
    w_tag_shift = 1'b0;
    w_tag_in    = 1'b0;
    w_pt_shift  = 1'b0;
    w_pt_in     = 1'b0;
    w_pt_clr    = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        w_tag_shift = exp_valid;
        w_tag_in    = exp_bit;
      end
      ST_COLLECT: begin
        w_tag_shift = w_take && (r_cnt < L_T);
        w_pt_shift  = w_take && (r_cnt < L_Y);
        w_pt_in     = dec_bit_pt;
      end
      ST_RELEASE: w_pt_shift = (r_cnt < L_Y) && !r_done;
      ST_FAIL:    w_pt_clr   = !r_done;
      default: ;
    endcase
  end

  // Expected tag is consumed LSB-first while collecting, so bit n sits at the LSB on dec cycle n.
  aead_bit_shifter #(.W(T)) u_tag (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (1'b0),
    .i_shift(w_tag_shift),
    .i_ser  (w_tag_in),
    .o_ser  (w_tag_lsb)
  );

  aead_bit_shifter #(.W(Y)) u_pt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_pt_clr),
    .i_shift(w_pt_shift),
    .i_ser  (w_pt_in),
    .o_ser  (w_pt_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_mis      <= 1'b0;
      r_pt_out   <= 1'b0;
      r_pt_valid <= 1'b0;
      r_done     <= 1'b0;
      r_auth_ok  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_pt_valid <= 1'b0;
      r_pt_out   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (exp_valid) begin
            r_auth_ok <= 1'b0;
            r_mis     <= 1'b0;
            if (T == 1) begin
              r_state <= ST_COLLECT;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_LOAD;
              r_cnt   <= CW'(1);
            end
          end
        end
        ST_LOAD: begin
          if (exp_valid) begin
            if (r_cnt == L_TM1) begin
              r_state <= ST_COLLECT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (dec_valid) begin
            r_mis <= r_mis | w_bit_mis;
            if (w_abort) begin
              r_state <= ST_FAIL;
              r_cnt   <= '0;
            end else if (r_cnt == L_NM1) begin
              r_state <= (r_mis || w_bit_mis) ? ST_FAIL : ST_RELEASE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (r_done) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == L_Y) begin
            r_done    <= 1'b1;
            r_auth_ok <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_pt_valid <= 1'b1;
            r_pt_out   <= w_pt_lsb;
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        ST_FAIL: begin
          if (r_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_done    <= 1'b1;
            r_auth_ok <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pt_out       = r_pt_out;
  assign pt_out_valid = r_pt_valid;
  assign done         = r_done;
  assign auth_ok      = r_auth_ok;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aead_tag_verifier.sv
// Scoreboard bench: two verifiers (Y=40 and Y=200, T=128) share one input stream.
module tb_aead_tag_verifier;

  localparam int unsigned TT = 128;
  localparam int unsigned PB = 200;

  logic clk = 1'b0;
  logic rst, exp_bit, exp_valid, dec_bit_pt, dec_bit_tag, dec_valid;
  logic a_pt, a_v, a_done, a_ok, a_busy;
  logic b_pt, b_v, b_done, b_ok, b_busy;

  always #5 clk = ~clk;

  aead_tag_verifier #(.Y(40), .T(TT)) dut40 (
    .clk(clk), .rst(rst), .exp_bit(exp_bit), .exp_valid(exp_valid),
    .dec_bit_pt(dec_bit_pt), .dec_bit_tag(dec_bit_tag), .dec_valid(dec_valid),
    .pt_out(a_pt), .pt_out_valid(a_v), .done(a_done), .auth_ok(a_ok), .busy(a_busy)
  );

  aead_tag_verifier #(.Y(PB), .T(TT)) dut200 (
    .clk(clk), .rst(rst), .exp_bit(exp_bit), .exp_valid(exp_valid),
    .dec_bit_pt(dec_bit_pt), .dec_bit_tag(dec_bit_tag), .dec_valid(dec_valid),
    .pt_out(b_pt), .pt_out_valid(b_v), .done(b_done), .auth_ok(b_ok), .busy(b_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int unsigned nz40 = 0;
  int unsigned nz200 = 0;
  int unsigned dec_edge [PB];

  logic        obs40[$], obs200[$], ver40[$], ver200[$];
  int unsigned tim40[$], tim200[$];
  logic        exp40[$], exp200[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_v) obs40.push_back(a_pt);
    else if (a_pt !== 1'b0) nz40++;
    if (b_v) obs200.push_back(b_pt);
    else if (b_pt !== 1'b0) nz200++;
    if (a_done) begin ver40.push_back(a_ok); tim40.push_back(cyc); end
    if (b_done) begin ver200.push_back(b_ok); tim200.push_back(cyc); end
  end

  function automatic logic [TT-1:0] rnd_tag();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [PB-1:0] rnd_pt();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_tag(input logic [TT-1:0] tag);
    for (int i = 0; i < TT; i++) begin
      exp_bit   = tag[i];
      exp_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 0) begin
        n_vec++;
        if ({a_ok, b_ok} !== 2'b00) begin
          n_err++;
          $display("FAIL ok_clear_on_load: got %b want 00", {a_ok, b_ok});
        end
      end
    end
    exp_valid = 1'b0;
    exp_bit   = 1'b0;
  endtask

  task automatic send_dec(input logic [TT-1:0] tag, input logic [PB-1:0] pt,
                          input int unsigned nbits, input bit gap);
    for (int i = 0; i < int'(nbits); i++) begin
      dec_valid   = 1'b1;
      dec_bit_pt  = pt[i];
      dec_bit_tag = (i < int'(TT)) ? tag[i] : 1'($urandom);
      @(posedge clk); #1;
      dec_edge[i] = cyc;
      dec_valid   = 1'b0;
      dec_bit_pt  = 1'($urandom);
      dec_bit_tag = 1'($urandom);
      if (gap) begin @(posedge clk); #1; end
    end
    dec_bit_pt  = 1'b0;
    dec_bit_tag = 1'b0;
  endtask

  task automatic run_msg(input string nm, input logic [TT-1:0] tag_rx,
                         input logic [TT-1:0] tag_dc, input logic [PB-1:0] pt, input bit gap);
    logic ok, got, want;
    int unsigned first_mis, e40, e200, t, s40, s200, k;
    ok = (tag_rx == tag_dc);
    first_mis = TT;
    for (int i = int'(TT) - 1; i >= 0; i--) if (tag_rx[i] != tag_dc[i]) first_mis = i;
    if (ok) begin
      for (int i = 0; i < 40; i++) exp40.push_back(pt[i]);
      for (int i = 0; i < int'(PB); i++) exp200.push_back(pt[i]);
    end
    s40 = nz40; s200 = nz200;
    send_tag(tag_rx);
    send_dec(tag_dc, pt, PB, gap);
    k = 0;
    while (k < 600 && (ver40.size() == 0 || ver200.size() == 0)) begin
      @(posedge clk); #1; k++;
    end
    repeat (3) begin @(posedge clk); #1; end

    if (ok) begin e40 = dec_edge[TT-1] + 41; e200 = dec_edge[PB-1] + PB + 1; end
    else    begin e40 = dec_edge[TT-1] + 1;  e200 = dec_edge[PB-1] + 1; end
`ifdef AEAD_TAGV_EARLY_ABORT_EN
    if (!ok) begin e40 = dec_edge[first_mis] + 1; e200 = e40; end
`endif

    n_vec++;
    if (ver40.size() != 1) begin
      n_err++; $display("FAIL %s done40_count: got %0d want 1", nm, ver40.size());
    end else begin
      got = ver40.pop_front(); t = tim40.pop_front();
      n_vec++;
      if (got !== ok) begin n_err++; $display("FAIL %s auth40: got %b want %b", nm, got, ok); end
      n_vec++;
      if (t != e40) begin n_err++; $display("FAIL %s done40_cycle: got %0d want %0d", nm, t, e40); end
    end
    n_vec++;
    if (ver200.size() != 1) begin
      n_err++; $display("FAIL %s done200_count: got %0d want 1", nm, ver200.size());
    end else begin
      got = ver200.pop_front(); t = tim200.pop_front();
      n_vec++;
      if (got !== ok) begin n_err++; $display("FAIL %s auth200: got %b want %b", nm, got, ok); end
      n_vec++;
      if (t != e200) begin n_err++; $display("FAIL %s done200_cycle: got %0d want %0d", nm, t, e200); end
    end
    while (ver40.size() > 0) begin void'(ver40.pop_front()); void'(tim40.pop_front()); end
    while (ver200.size() > 0) begin void'(ver200.pop_front()); void'(tim200.pop_front()); end

    for (int i = 0; exp40.size() > 0; i++) begin
      want = exp40.pop_front();
      n_vec++;
      if (obs40.size() == 0) begin
        n_err++; $display("FAIL %s pt40_missing bit %0d: got none want %b", nm, i, want);
      end else begin
        got = obs40.pop_front();
        if (got !== want) begin n_err++; $display("FAIL %s pt40 bit %0d: got %b want %b", nm, i, got, want); end
      end
    end
    for (int i = 0; exp200.size() > 0; i++) begin
      want = exp200.pop_front();
      n_vec++;
      if (obs200.size() == 0) begin
        n_err++; $display("FAIL %s pt200_missing bit %0d: got none want %b", nm, i, want);
      end else begin
        got = obs200.pop_front();
        if (got !== want) begin n_err++; $display("FAIL %s pt200 bit %0d: got %b want %b", nm, i, got, want); end
      end
    end
    n_vec++;
    if (obs40.size() != 0 || obs200.size() != 0) begin
      n_err++; $display("FAIL %s pt_extra: got %0d/%0d want 0/0", nm, obs40.size(), obs200.size());
    end
    obs40.delete(); obs200.delete();

    n_vec++;
    if (nz40 != s40 || nz200 != s200) begin
      n_err++; $display("FAIL %s pt_zero_when_invalid: got %0d/%0d bad cycles want 0", nm, nz40 - s40, nz200 - s200);
    end
    n_vec++;
    if ({a_busy, b_busy, a_ok, b_ok} !== {2'b00, ok, ok}) begin
      n_err++; $display("FAIL %s idle_hold: got %b want %b", nm, {a_busy, b_busy, a_ok, b_ok}, {2'b00, ok, ok});
    end
    if (!ok) begin
      n_vec++;
      if (dut40.u_pt.r_data !== '0 || dut200.u_pt.r_data !== '0) begin
        n_err++; $display("FAIL %s buf_zero: got %h / %h want 0", nm, dut40.u_pt.r_data, dut200.u_pt.r_data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if ({a_pt, a_v, a_done, a_ok, a_busy, b_pt, b_v, b_done, b_ok, b_busy} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", {a_pt, a_v, a_done, a_ok, a_busy, b_pt, b_v, b_done, b_ok, b_busy});
    end
    n_vec++;
    if (dut40.u_pt.r_data !== '0 || dut200.u_pt.r_data !== '0) begin
      n_err++; $display("FAIL reset_buf: got %h / %h want 0", dut40.u_pt.r_data, dut200.u_pt.r_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    logic [TT-1:0] tg;
    logic [PB-1:0] p;
    tg = rnd_tag();
    p  = rnd_pt();
    p[39:0] = 40'hA5A5A5A5A5;
    run_msg("pass_a5", tg, tg, p, 1'b0);
  endtask

  task automatic test_fail_msb();
    logic [TT-1:0] tg, td;
    tg = rnd_tag();
    td = tg;
    td[TT-1] = ~td[TT-1];
    run_msg("fail_bit127", tg, td, rnd_pt(), 1'b0);
  endtask

  task automatic test_fail_bit3();
    logic [TT-1:0] tg, td;
    tg = rnd_tag();
    td = tg;
    td[3] = ~td[3];
    run_msg("fail_bit3", tg, td, rnd_pt(), 1'b0);
  endtask

  task automatic test_y_gt_t();
    logic [TT-1:0] tg;
    tg = rnd_tag();
    run_msg("y200_pass", tg, tg, rnd_pt(), 1'b0);
  endtask

  task automatic test_rst_mid();
    logic [TT-1:0] tg;
    tg = rnd_tag();
    send_tag(tg);
    send_dec(tg, rnd_pt(), 60, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({a_pt, a_v, a_done, a_ok, a_busy, b_pt, b_v, b_done, b_ok, b_busy} !== 10'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %b want 0", {a_pt, a_v, a_done, a_ok, a_busy, b_pt, b_v, b_done, b_ok, b_busy});
    end
    rst = 1'b0;
    repeat (300) begin @(posedge clk); #1; end
    n_vec++;
    if (ver40.size() + ver200.size() + obs40.size() + obs200.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_no_done: got %0d events want 0", ver40.size() + ver200.size() + obs40.size() + obs200.size());
    end
    ver40.delete(); ver200.delete(); tim40.delete(); tim200.delete(); obs40.delete(); obs200.delete();
    tg = rnd_tag();
    run_msg("after_rst", tg, tg, rnd_pt(), 1'b0);
  endtask

  task automatic test_gapped();
    logic [TT-1:0] tg, td;
    logic [PB-1:0] p;
    tg = rnd_tag();
    p  = rnd_pt();
    p[39:0] = 40'hA5A5A5A5A5;
    run_msg("gap_pass", tg, tg, p, 1'b1);
    td = tg;
    td[64] = ~td[64];
    run_msg("gap_fail", tg, td, p, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [TT-1:0] tg, td;
    tg = rnd_tag();
    td = tg;
    td[0] = ~td[0];
    run_msg("b2b_1", tg, tg, rnd_pt(), 1'b0);
    run_msg("b2b_2", tg, td, rnd_pt(), 1'b0);
    run_msg("b2b_3", ~tg, ~tg, {PB{1'b1}}, 1'b0);
  endtask

  initial begin
    rst = 1'b1; exp_bit = 1'b0; exp_valid = 1'b0;
    dec_bit_pt = 1'b0; dec_bit_tag = 1'b0; dec_valid = 1'b0;
    test_reset();
    test_pass();
    test_fail_msb();
    test_fail_bit3();
    test_y_gt_t();
    test_rst_mid();
    test_gapped();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
